// File: rtl/seq_alu_exec.sv
// Multicycle execute unit: logic/arithmetic ops finish in one cycle, shifts
// iterate one bit per cycle before the result is registered.
module seq_alu_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      aluselect,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] aluresult,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic {IDLE, SHIFT} state_e;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shop_e;

    state_e          state_q, state_d;
    shop_e           shop_q, shop_d;
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shift_next;
    logic            is_shift;

    always_comb begin
        alu_res = '0;
        case (aluselect)
            4'd0:    alu_res = srca + srcb;
            4'd1:    alu_res = srca - srcb;
            4'd2:    alu_res = srca & srcb;
            4'd3:    alu_res = srca | srcb;
            4'd4:    alu_res = srca ^ srcb;
            4'd5:    alu_res = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, (srca < srcb)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        shift_next = shreg_q;
        case (shop_q)
            SH_LL:   shift_next = {shreg_q[XLEN-2:0], 1'b0};
            SH_RL:   shift_next = {1'b0, shreg_q[XLEN-1:1]};
            SH_RA:   shift_next = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: shift_next = shreg_q;
        endcase
    end

    assign is_shift = (aluselect == 4'd7) || (aluselect == 4'd8) || (aluselect == 4'd9);

    always_comb begin
        state_d   = state_q;
        shop_d    = shop_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift) begin
                        shreg_d = srca;
                        cnt_d   = srcb[SHW-1:0];
                        state_d = SHIFT;
                        case (aluselect)
                            4'd7:    shop_d = SH_LL;
                            4'd8:    shop_d = SH_RL;
                            default: shop_d = SH_RA;
                        endcase
                    end else begin
                        // Codes 10..15 fall through the ALU decode as zero.
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = (aluselect >= 4'd10);
                        done_d    = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = shift_next;
                    cnt_d   = cnt_q - SHW'(1);
                end else begin
                    result_d  = shreg_q;
                    zero_d    = (shreg_q == '0);
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shop_q    <= SH_LL;
            shreg_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shop_q    <= shop_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign aluresult = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu_exec.sv
// Self-checking bench for seq_alu_exec: an operation-level reference model
// predicts every output each cycle, and directed cases pin literal values.
module tb_seq_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  aluselect = 4'd0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        busy;
    logic        done;
    logic [31:0] aluresult;
    logic        zero;
    logic        illegal;

    int total = 0;
    int bad = 0;

    seq_alu_exec #(.XLEN(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .aluselect(aluselect),
        .srca(srca),
        .srcb(srcb),
        .busy(busy),
        .done(done),
        .aluresult(aluresult),
        .zero(zero),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference model: works per operation, predicting the completion edge
    // from the shift amount instead of stepping a counter.
    logic [31:0] mResult = '0;
    logic        mZero = 1'b0;
    logic        mIllegal = 1'b0;
    logic        mDone = 1'b0;
    logic        mBusy = 1'b0;
    logic        mPending = 1'b0;
    logic [31:0] mPendRes = '0;
    int          mFinish = 0;
    int          cyc = 0;

    function automatic logic [31:0] modelAlu(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (sel)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: return $unsigned($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mResult  <= '0;
            mZero    <= 1'b0;
            mIllegal <= 1'b0;
            mDone    <= 1'b0;
            mBusy    <= 1'b0;
            mPending <= 1'b0;
        end else begin
            cyc   <= cyc + 1;
            mDone <= 1'b0;
            if (mPending) begin
                if (cyc == mFinish) begin
                    mResult  <= mPendRes;
                    mZero    <= (mPendRes == 32'd0);
                    mIllegal <= 1'b0;
                    mDone    <= 1'b1;
                    mBusy    <= 1'b0;
                    mPending <= 1'b0;
                end
            end else if (start) begin
                if (aluselect >= 4'd7 && aluselect <= 4'd9) begin
                    mPendRes <= modelAlu(aluselect, srca, srcb);
                    mFinish  <= cyc + int'(srcb % 32) + 1;
                    mPending <= 1'b1;
                    mBusy    <= 1'b1;
                end else begin
                    mResult  <= modelAlu(aluselect, srca, srcb);
                    mZero    <= (modelAlu(aluselect, srca, srcb) == 32'd0);
                    mIllegal <= (aluselect >= 4'd10);
                    mDone    <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle the outputs must equal the model's prediction.
    always @(negedge clk) begin
        checkOutput("cyc_busy", {31'd0, busy}, {31'd0, mBusy});
        checkOutput("cyc_done", {31'd0, done}, {31'd0, mDone});
        checkOutput("cyc_result", aluresult, mResult);
        checkOutput("cyc_zero", {31'd0, zero}, {31'd0, mZero});
        checkOutput("cyc_illegal", {31'd0, illegal}, {31'd0, mIllegal});
    end

    task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        aluselect = sel;
        srca      = a;
        srcb      = b;
        @(negedge clk);
        start     = 1'b0;
        aluselect = 4'($urandom_range(0, 15));
        srca      = $urandom;
        srcb      = $urandom;
    endtask

    task automatic waitDone(input string name, input int budget, output int lat, output int busyCnt);
        lat = 1;
        busyCnt = 0;
        while (!done && lat <= budget) begin
            if (busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got no done expected done within %0d", name, budget);
        end
    endtask

    task automatic runOp(input string name, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input int expLat);
        int lat;
        int bc;
        applyStimulus(sel, a, b);
        waitDone(name, 40, lat, bc);
        checkOutput({name, "_res"}, aluresult, expRes);
        checkOutput({name, "_model"}, mResult, expRes);
        checkOutput({name, "_lat"}, lat, expLat);
        checkOutput({name, "_busycnt"}, bc, (expLat > 1) ? expLat - 1 : 0);
    endtask

    initial begin
        int dn;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_result", aluresult, 32'd0);
        checkOutput("rst_zero", {31'd0, zero}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] add wrap, compares, sub");
        runOp("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        checkOutput("add_zero", {31'd0, zero}, 32'd1);
        runOp("slt", 4'd5, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        runOp("sltu", 4'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        runOp("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        runOp("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        runOp("or", 4'd3, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1);

        $display("[TB] long shifts");
        runOp("sra31", 4'd9, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, 33);
        runOp("srl31", 4'd8, 32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 33);
        runOp("sll4_hibits", 4'd7, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 6);

        $display("[TB] shamt 0 with start while busy");
        @(negedge clk);
        start = 1'b1; aluselect = 4'd7; srca = 32'h1; srcb = 32'h0;
        @(negedge clk);
        checkOutput("sll0_busy", {31'd0, busy}, 32'd1);
        aluselect = 4'd0; srca = 32'd100; srcb = 32'd1;
        @(negedge clk);
        start = 1'b0;
        dn = int'(done);
        checkOutput("sll0_res", aluresult, 32'h1);
        repeat (4) begin
            @(negedge clk);
            dn += int'(done);
        end
        checkOutput("sll0_done_count", dn, 1);
        checkOutput("sll0_res_held", aluresult, 32'h1);

        $display("[TB] reset mid-shift");
        @(negedge clk);
        start = 1'b1; aluselect = 4'd7; srca = 32'h1; srcb = 32'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_result", aluresult, 32'd0);
        checkOutput("abort_zero", {31'd0, zero}, 32'd0);
        checkOutput("abort_illegal", {31'd0, illegal}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            dn += int'(done);
        end
        checkOutput("abort_no_done", dn, 0);
        runOp("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1);

        $display("[TB] illegal code");
        runOp("illegal_c", 4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1);
        checkOutput("illegal_flag", {31'd0, illegal}, 32'd1);
        checkOutput("illegal_zero", {31'd0, zero}, 32'd1);
        runOp("xor", 4'd4, 32'hF0, 32'hFF, 32'h0F, 1);
        checkOutput("xor_illegal", {31'd0, illegal}, 32'd0);

        $display("[TB] back-to-back non-shift");
        @(negedge clk);
        start = 1'b1; aluselect = 4'd0; srca = 32'd10; srcb = 32'd20;
        @(negedge clk);
        checkOutput("b2b_first", aluresult, 32'd30);
        aluselect = 4'd1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_done2", {31'd0, done}, 32'd1);
        checkOutput("b2b_second", aluresult, 32'hFFFF_FFF6);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end expected end before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
